// File: rtl/future_pkg.sv
// Shared types and round-level helpers for the FUTURE 64-bit block cipher.
// State is MSB-first: column j = bits [16j +: 16], row r of column j = bits [16j+4r +: 4].
package future_pkg;

    localparam int NROUNDS_DEF = 10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    // S-box table and MixColumn matrix, packed MSB-first: entry x at [4x +: 4], M[r][c] at [16r+4c +: 4]
    localparam logic [0:63] SBOX_T = 64'h13027E4D9AC6F58B;
    localparam logic [0:63] MIX_M  = 64'h8918329923899981;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX_T[{x, 2'b00} +: 4];
    endfunction

    // GF(2^4) multiply modulo x^4 + x + 1
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [0:63] shift_rows(input logic [0:63] x);
        logic [0:63] y;
        y = '0;
        for (int j = 0; j < 4; j++)
            for (int r = 0; r < 4; r++)
                y[16*j+4*r +: 4] = x[16*((j+r)%4)+4*r +: 4];
        return y;
    endfunction

    function automatic logic [0:63] round_key(input logic [0:63] k0, input logic [0:63] k1,
                                              input logic [3:0] rnd);
        logic [63:0] b;
        int          sh;
        b  = rnd[0] ? k1 : k0;
        sh = 5 * int'(rnd[3:1]);
        if (sh != 0) b = (b << sh) | (b >> (64 - sh));
        b[3:0] = b[3:0] ^ rnd;
        return b;
    endfunction

endpackage

// File: rtl/future_round.sv
// Combinational FUTURE round: column S-box/mix, ShiftRows, round-key XOR.
module future_round
    import future_pkg::*;
(
    input  logic [0:63] state_i,
    input  logic [0:15] s_i,
    input  logic [0:63] rk_i,
    output logic [0:63] state_o
);

    logic [0:63] sm;

    for (genvar j = 0; j < 4; j++) begin : g_col
        sbmx u_sbmx (
            .col_i (state_i[16*j +: 16]),
            .s_i   (s_i),
            .col_o (sm[16*j +: 16])
        );
    end

    assign state_o = shift_rows(sm) ^ rk_i;

endmodule

// File: rtl/sbmx.sv
// One state column: S-box on each nibble, then a per-bit select between the
// MixColumn result (s=1) and the plain S-box output (s=0).
module sbmx
    import future_pkg::*;
(
    input  logic [0:15] col_i,
    input  logic [0:15] s_i,
    output logic [0:15] col_o
);

    logic [0:15] sb;
    logic [0:15] mx;

    always_comb begin
        sb = '0;
        mx = '0;
        for (int r = 0; r < 4; r++)
            sb[4*r +: 4] = sbox4(col_i[4*r +: 4]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mx[4*r +: 4] = mx[4*r +: 4] ^ gf_mul(MIX_M[16*r+4*c +: 4], sb[4*c +: 4]);
    end

    assign col_o = (mx & s_i) | (sb & ~s_i);

endmodule

// File: rtl/future_enc_core.sv
// Iterative FUTURE encryption core: whitening on accept, one round per cycle,
// ciphertext held in the state register until the consumer takes it.
module future_enc_core
    import future_pkg::*;
#(
    parameter int NROUNDS = NROUNDS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:63]  pt,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:63]  ct
);

    localparam logic [3:0] LAST = 4'(NROUNDS);

    fsm_e        fsm_q;
    logic [3:0]  round_q;
    logic [0:63] k0_q, k1_q, state_q;
    logic        in_ready_q, out_valid_q;

    logic [0:15] s_d;
    logic [0:63] rk_d, state_d;

    // Final round skips MixColumn
    assign s_d  = (round_q == LAST) ? 16'h0000 : 16'hFFFF;
    assign rk_d = round_key(k0_q, k1_q, round_q);

    future_round u_round (
        .state_i (state_q),
        .s_i     (s_d),
        .rk_i    (rk_d),
        .state_o (state_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            state_q     <= '0;
            round_q     <= '0;
            k0_q        <= '0;
            k1_q        <= '0;
        end else begin
            case (fsm_q)
                IDLE: if (in_valid) begin
                    k0_q       <= key[0:63];
                    k1_q       <= key[64:127];
                    state_q    <= pt ^ key[0:63];
                    round_q    <= 4'd1;
                    fsm_q      <= RUN;
                    in_ready_q <= 1'b0;
                end
                RUN: begin
                    state_q <= state_d;
                    round_q <= round_q + 4'd1;
                    if (round_q == LAST) begin
                        fsm_q       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    fsm_q       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ct        = state_q;

endmodule
